// File: rtl/vregfile.sv
// ----------------------------------------------------------------------------
// vregfile -- vector register file with forwarding and a bulk-clear engine
//
// Holds NUM_REGS registers of VLEN bits. NUM_RD_PORTS combinational read
// ports see a same-cycle accepted write byte-accurately. A single write port
// updates only the bytes selected by wbe_i. A two-state clear engine sweeps
// the file to zero, one register per cycle, while refusing writes.
//
// Optional feature: define VRF_PARITY_EN to store one even-parity bit per
// byte and report per-port parity mismatches on parity_err_o. Without it,
// no parity storage is built and parity_err_o is tied to 0.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   raddr_i       read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdata_o       read data, port p at [p*VLEN +: VLEN]
//   we_i          write request
//   waddr_i       write address
//   wdata_i       write data
//   wbe_i         byte enables, bit b covers wdata_i[8b+7:8b]
//   wr_ack_o      write accepted this cycle (we_i && !clr_busy_o)
//   clr_req_i     bulk-clear request
//   clr_busy_o    clear engine running
//   clr_done_o    one-cycle pulse after the last register is cleared
//   wr_count_o    saturating count of accepted writes
//   parity_err_o  per-port parity error
// ----------------------------------------------------------------------------
module vregfile #(
    parameter  int VLEN         = 128,
    parameter  int NUM_REGS     = 32,
    parameter  int NUM_RD_PORTS = 3,
    localparam int ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD_PORTS*VLEN-1:0]   rdata_o,
    input  logic                           we_i,
    input  logic [ADDR_W-1:0]              waddr_i,
    input  logic [VLEN-1:0]                wdata_i,
    input  logic [VLEN/8-1:0]              wbe_i,
    output logic                           wr_ack_o,
    input  logic                           clr_req_i,
    output logic                           clr_busy_o,
    output logic                           clr_done_o,
    output logic [31:0]                    wr_count_o,
    output logic [NUM_RD_PORTS-1:0]        parity_err_o
);

    localparam int                NB       = VLEN / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                clr_done_q;
    logic [31:0]         wr_count_q;
    logic [VLEN-1:0]     regs [NUM_REGS];

    logic [VLEN-1:0]         bmask;
    logic [VLEN-1:0]         wmerged;
    logic [NUM_RD_PORTS-1:0] fwd;

    assign clr_busy_o = (state_q == CLEAR);
    assign clr_done_o = clr_done_q;
    assign wr_count_o = wr_count_q;
    assign wr_ack_o   = we_i && !clr_busy_o;

    // Write data merged with the stored target register. This is both the
    // value committed at the edge and the value forwarded to matching reads.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        bmask = '0;
        for (int b = 0; b < NB; b++) begin
            bmask[b*8 +: 8] = {8{wbe_i[b]}};
        end
        wmerged = (wdata_i & bmask) | (regs[waddr_i] & ~bmask);
    end

    // Read ports. Forwarding only happens for an accepted write, so a busy
    // clear engine naturally disables it.
    always_comb begin
        rdata_o = '0;
        fwd     = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            fwd[p] = wr_ack_o && (raddr_i[p*ADDR_W +: ADDR_W] == waddr_i);
            rdata_o[p*VLEN +: VLEN] = fwd[p] ? wmerged
                                             : regs[raddr_i[p*ADDR_W +: ADDR_W]];
        end
    end

    // Clear FSM next-state logic. Requests arriving during CLEAR are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req_i) state_d = CLEAR;
            CLEAR:   if (clr_cnt_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset explicitly because the file must read as zero after reset; this keeps it out of plain RAM macros.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            wr_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            clr_done_q <= (state_q == CLEAR) && (clr_cnt_q == LAST_IDX);

            // The counter wraps to 0 after the last index because NUM_REGS
            // is a power of two; in IDLE it is held at 0 for the next sweep.
            if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            else                  clr_cnt_q <= '0;

            if (state_q == CLEAR) begin
                regs[clr_cnt_q] <= '0;
            end else if (wr_ack_o) begin
                regs[waddr_i] <= wmerged;
            end

            if (wr_ack_o && (wr_count_q != 32'hFFFF_FFFF)) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

`ifdef VRF_PARITY_EN
    logic [NB-1:0] par [NUM_REGS];
    logic [NB-1:0] wpar;

    always_comb begin
        wpar = '0;
        for (int b = 0; b < NB; b++) begin
            wpar[b] = ^wmerged[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                par[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            par[clr_cnt_q] <= '0;
        end else if (wr_ack_o) begin
            par[waddr_i] <= wpar;
        end
    end

    // A byte taken from wdata_i carries its own fresh parity and never flags;
    // bytes taken from storage are checked against their stored parity bit.
    always_comb begin
        parity_err_o = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int b = 0; b < NB; b++) begin
                if (!(fwd[p] && wbe_i[b]) &&
                    ((^regs[raddr_i[p*ADDR_W +: ADDR_W]][b*8 +: 8]) !=
                     par[raddr_i[p*ADDR_W +: ADDR_W]][b])) begin
                    parity_err_o[p] = 1'b1;
                end
            end
        end
    end
`else
    assign parity_err_o = '0;
`endif

endmodule

// File: tb/tb_vregfile.sv
// ----------------------------------------------------------------------------
// tb_vregfile -- self-checking bench for vregfile (default parameters)
//
// A table of write/read vectors with expected read data, ack and count is
// applied through a scoreboard queue; hand-written sequences then cover the
// bulk clear, back-to-back clears, reset during a clear and, when
// VRF_PARITY_EN is defined, parity error detection.
// ----------------------------------------------------------------------------
module tb_vregfile;

    localparam int VLEN = 128;
    localparam int NR   = 32;
    localparam int NP   = 3;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NP*AW-1:0]    raddr;
    logic [NP*VLEN-1:0]  rdata;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [VLEN-1:0]     wdata;
    logic [VLEN/8-1:0]   wbe;
    logic                wr_ack;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;
    logic [31:0]         wr_count;
    logic [NP-1:0]       parity_err;

    vregfile #(.VLEN(VLEN), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raddr_i      (raddr),
        .rdata_o      (rdata),
        .we_i         (we),
        .waddr_i      (waddr),
        .wdata_i      (wdata),
        .wbe_i        (wbe),
        .wr_ack_o     (wr_ack),
        .clr_req_i    (clr_req),
        .clr_busy_o   (clr_busy),
        .clr_done_o   (clr_done),
        .wr_count_o   (wr_count),
        .parity_err_o (parity_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [NP*VLEN-1:0] act,
                         input logic [NP*VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NP*AW-1:0] ra(input int p2, input int p1, input int p0);
        return {AW'(p2), AW'(p1), AW'(p0)};
    endfunction

    function automatic logic [VLEN-1:0] fill_val(input int i);
        return {4{32'h1000_0001 * 32'(i + 1)}};
    endfunction

    typedef struct {
        logic              we;
        logic [AW-1:0]     waddr;
        logic [VLEN-1:0]   wdata;
        logic [VLEN/8-1:0] wbe;
        logic [NP*AW-1:0]  raddr;
        logic [NP*VLEN-1:0] exp_rdata;
        logic              exp_ack;
        logic [31:0]       exp_count;
    } vec_t;

    typedef struct {
        logic [NP*VLEN-1:0] rdata;
        logic               ack;
        logic [31:0]        count;
    } exp_t;

    exp_t sb_q[$];
    logic [VLEN-1:0] model [NR];

    // Drive one vector, queue its expectation, compare mid-cycle, commit.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        we    = v.we;
        waddr = v.waddr;
        wdata = v.wdata;
        wbe   = v.wbe;
        raddr = v.raddr;
        sb_q.push_back('{rdata: v.exp_rdata, ack: v.exp_ack, count: v.exp_count});
        @(negedge clk);
        e = sb_q.pop_front();
        check($sformatf("vec%0d rdata", idx), rdata, e.rdata);
        check($sformatf("vec%0d ack", idx), wr_ack, e.ack);
        check($sformatf("vec%0d count", idx), wr_count, e.count);
        check($sformatf("vec%0d parity", idx), parity_err, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [VLEN-1:0] d);
        we = 1'b1; waddr = AW'(a); wdata = d; wbe = '1;
        @(posedge clk);
        #1;
        we = 1'b0;
        model[a] = d;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < NR; a++) begin
            raddr = ra(a, a, a);
            @(negedge clk);
            check($sformatf("%s reg%0d", tag, a), rdata, '0);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [VLEN-1:0] A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [VLEN-1:0] M = 128'h0123456789ABCDEF_FEDCBA98AAAAAAAA;
    localparam logic [VLEN-1:0] D = 128'h00000000_00000000_00000000_DEADBEEF;
    localparam logic [VLEN-1:0] F = 128'hFF000000_00000000_00000000_000000FF;
    localparam logic [VLEN-1:0] Z = '0;

    vec_t vecs [11];
    int   busy_n, done_n, wait_n;
    logic bseq [34];
    logic dseq [34];
    int   ones;
    logic [31:0] count_before;

    initial begin
        // Vector table: inputs then expected {port2, port1, port0}, ack, count.
        vecs[0]  = '{1'b0, 5'd0, Z,               16'h0000, ra(0,0,0), {Z,Z,Z}, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 5'd5, A,               16'hFFFF, ra(1,2,5), {Z,Z,A}, 1'b1, 32'd0};
        vecs[2]  = '{1'b1, 5'd5, {16{8'hAA}},     16'h000F, ra(0,0,5), {Z,Z,M}, 1'b1, 32'd1};
        vecs[3]  = '{1'b0, 5'd0, Z,               16'h0000, ra(0,5,5), {Z,M,M}, 1'b0, 32'd2};
        vecs[4]  = '{1'b1, 5'd7, 128'h11111111_22222222_33333333_DEADBEEF,
                                                  16'h000F, ra(7,7,7), {D,D,D}, 1'b1, 32'd2};
        vecs[5]  = '{1'b1, 5'd0, {16{8'h11}},     16'h0000, ra(0,5,7), {Z,M,D}, 1'b1, 32'd3};
        vecs[6]  = '{1'b0, 5'd0, Z,               16'h0000, ra(5,7,0), {M,D,Z}, 1'b0, 32'd4};
        vecs[7]  = '{1'b1, 5'd0, {16{8'hFF}},     16'h8001, ra(7,0,0), {D,F,F}, 1'b1, 32'd4};
        vecs[8]  = '{1'b0, 5'd0, Z,               16'h0000, ra(0,0,0), {F,F,F}, 1'b0, 32'd5};
        vecs[9]  = '{1'b1, 5'd5, Z,               16'hFFFF, ra(5,3,5), {Z,Z,Z}, 1'b1, 32'd5};
        vecs[10] = '{1'b0, 5'd0, Z,               16'h0000, ra(5,5,5), {Z,Z,Z}, 1'b0, 32'd6};

        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        raddr = '0; clr_req = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("reset count", wr_count, '0);
        check("reset busy", clr_busy, '0);
        check("reset done", clr_done, '0);
        check("reset parity", parity_err, '0);
        check_all_zero("reset");
        @(posedge clk);
        #1;

        // Table-driven writes, masking and forwarding.
        foreach (vecs[i]) apply(vecs[i], i);
        we = 1'b0;
        check("sb empty", 32'(sb_q.size()), 32'd0);

        // Fill every register with nonzero data and read it back.
        for (int i = 0; i < NR; i++) write_reg(i, fill_val(i));
        for (int a = 0; a < NR; a++) begin
            raddr = ra((a + 2) % NR, (a + 1) % NR, a);
            @(negedge clk);
            check($sformatf("fill reg%0d", a), rdata,
                  {model[(a + 2) % NR], model[(a + 1) % NR], model[a]});
        end
        @(negedge clk);
        check("fill count", wr_count, 32'd38);
        @(posedge clk);
        #1;

        // Bulk clear with a refused write in busy cycle 10.
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        busy_n = 0; done_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_n == 10 && clr_busy) begin
                we = 1'b1; waddr = 5'd31; wdata = '1; wbe = '1; raddr = ra(5, 0, 31);
            end else begin
                we = 1'b0;
            end
            @(negedge clk);
            if (clr_busy) begin
                if (busy_n == 10) begin
                    check("clear busy write ack", wr_ack, '0);
                    check("clear busy read", rdata, {Z, Z, model[31]});
                end
                busy_n++;
            end
            if (clr_done) done_n++;
            @(posedge clk);
            #1;
        end
        we = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        check("clear busy cycles", busy_n, 32);
        check("clear done pulses", done_n, 1);
        check("clear count kept", wr_count, 32'd38);
        check_all_zero("cleared");
        @(posedge clk);
        #1;

        // Request held high: ignored during CLEAR, restarts on the done cycle.
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            bseq[c] = clr_busy;
            dseq[c] = clr_done;
            @(posedge clk);
            #1;
        end
        clr_req = 1'b0;
        ones = 0;
        for (int c = 0; c < 32; c++) if (bseq[c] === 1'b1) ones++;
        check("held req busy run", ones, 32);
        check("held req gap busy", bseq[32], 1'b0);
        check("held req gap done", dseq[32], 1'b1);
        check("held req restart", bseq[33], 1'b1);
        wait_n = 0;
        while (!clr_done && wait_n < 40) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        check("second sweep done seen", clr_done, 1'b1);
        @(posedge clk);
        #1;

        // Reset in the middle of a clear; registers above the sweep point
        // still hold data until the reset.
        write_reg(20, fill_val(20));
        write_reg(31, fill_val(31));
        count_before = wr_count;
        we = 1'b1; waddr = 5'd12; wdata = fill_val(12); wbe = '1; clr_req = 1'b1;
        @(negedge clk);
        check("req+write ack", wr_ack, 1'b1);
        @(posedge clk);
        #1;
        we = 1'b0; clr_req = 1'b0;
        check("req+write count", wr_count, count_before + 32'd1);
        busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_busy) busy_n++;
            @(posedge clk);
            #1;
            if (busy_n == 12) break;
        end
        check("reached busy cycle 12", busy_n, 12);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_busy) busy_n++;
            if (clr_done) done_n++;
        end
        check("abort busy", busy_n, 0);
        check("abort no done", done_n, 0);
        check("abort count", wr_count, '0);
        check_all_zero("abort");
        @(posedge clk);
        #1;

`ifdef VRF_PARITY_EN
        // Corrupt one stored bit of reg 3 byte 2.
        write_reg(3, fill_val(3));
        dut.regs[3][16] = ~dut.regs[3][16];
        raddr = ra(1, 3, 0);
        @(negedge clk);
        check("parity flag", parity_err, 3'b010);
        @(posedge clk);
        #1;
        we = 1'b1; waddr = 5'd3; wdata = fill_val(7); wbe = '1;
        @(negedge clk);
        check("parity forwarded", parity_err, 3'b000);
        check("parity forwarded data", rdata[VLEN +: VLEN], fill_val(7));
        @(posedge clk);
        #1;
        we = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
